// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode encoding and default widths for the integer ALU
package alu_pkg;

    localparam int DEF_ROB_SIZE_WIDTH = 4;
    localparam int OP_L1_WIDTH        = 3;

    typedef enum logic [OP_L1_WIDTH-1:0] {
        CALC_ADD  = 3'd0,
        CALC_SLL  = 3'd1,
        CALC_SLT  = 3'd2,
        CALC_SLTU = 3'd3,
        CALC_XOR  = 3'd4,
        CALC_SRL  = 3'd5,
        CALC_OR   = 3'd6,
        CALC_AND  = 3'd7
    } calc_op_e;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - purely combinational RV32I integer datapath, reusable by other ALU ports
module alu_core
    import alu_pkg::*;
(
    input  calc_op_e    op_l1,
    input  logic        op_l2,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (op_l1)
            CALC_ADD:  result = op_l2 ? (a - b) : (a + b);
            CALC_SLL:  result = a << shamt;
            CALC_SLT:  result = {31'b0, $signed(a) < $signed(b)};
            CALC_SLTU: result = {31'b0, a < b};
            CALC_XOR:  result = a ^ b;
            CALC_SRL:  result = op_l2 ? 32'($signed(a) >>> shamt) : (a >> shamt);
            CALC_OR:   result = a | b;
            CALC_AND:  result = a & b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - two-stage pipelined ALU: E1 operand capture, E2 compute and broadcast
module alu
    import alu_pkg::*;
#(
    parameter int ROB_SIZE_WIDTH       = DEF_ROB_SIZE_WIDTH,
    parameter int CALC_OP_L1_NUM_WIDTH = OP_L1_WIDTH
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            rdy_in,
    input  logic                            need_flush_in,
    input  logic                            rs2alu_ready,
    input  logic [CALC_OP_L1_NUM_WIDTH-1:0] rs2alu_op_L1,
    input  logic                            rs2alu_op_L2,
    input  logic [31:0]                     rs2alu_opr1,
    input  logic [31:0]                     rs2alu_opr2,
    input  logic [ROB_SIZE_WIDTH-1:0]       rs2alu_rob_id,
    output logic                            alu_valid,
    output logic [31:0]                     alu_value,
    output logic [ROB_SIZE_WIDTH-1:0]       alu_dependency
);

    logic                            e1_valid_q, e1_valid_d;
    logic [CALC_OP_L1_NUM_WIDTH-1:0] e1_op_l1_q, e1_op_l1_d;
    logic                            e1_op_l2_q, e1_op_l2_d;
    logic [31:0]                     e1_opr1_q, e1_opr1_d;
    logic [31:0]                     e1_opr2_q, e1_opr2_d;
    logic [ROB_SIZE_WIDTH-1:0]       e1_rob_id_q, e1_rob_id_d;
    logic                            alu_valid_q, alu_valid_d;
    logic [31:0]                     alu_value_q, alu_value_d;
    logic [ROB_SIZE_WIDTH-1:0]       alu_dep_q, alu_dep_d;
    logic [31:0]                     core_result;

    alu_core u_core (
        .op_l1  (calc_op_e'(e1_op_l1_q)),
        .op_l2  (e1_op_l2_q),
        .a      (e1_opr1_q),
        .b      (e1_opr2_q),
        .result (core_result)
    );

    always_comb begin
        e1_valid_d  = e1_valid_q;
        e1_op_l1_d  = e1_op_l1_q;
        e1_op_l2_d  = e1_op_l2_q;
        e1_opr1_d   = e1_opr1_q;
        e1_opr2_d   = e1_opr2_q;
        e1_rob_id_d = e1_rob_id_q;
        alu_valid_d = alu_valid_q;
        alu_value_d = alu_value_q;
        alu_dep_d   = alu_dep_q;
        // rdy_in low freezes everything, including a pending flush request
        if (rdy_in) begin
            e1_valid_d  = rs2alu_ready && !need_flush_in;
            alu_valid_d = e1_valid_q && !need_flush_in;
            if (rs2alu_ready) begin
                e1_op_l1_d  = rs2alu_op_L1;
                e1_op_l2_d  = rs2alu_op_L2;
                e1_opr1_d   = rs2alu_opr1;
                e1_opr2_d   = rs2alu_opr2;
                e1_rob_id_d = rs2alu_rob_id;
            end
            // Result bus keeps its last value when no fresh result arrives
            if (e1_valid_q && !need_flush_in) begin
                alu_value_d = core_result;
                alu_dep_d   = e1_rob_id_q;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            e1_valid_q  <= 1'b0;
            e1_op_l1_q  <= '0;
            e1_op_l2_q  <= 1'b0;
            e1_opr1_q   <= '0;
            e1_opr2_q   <= '0;
            e1_rob_id_q <= '0;
            alu_valid_q <= 1'b0;
            alu_value_q <= '0;
            alu_dep_q   <= '0;
        end else begin
            e1_valid_q  <= e1_valid_d;
            e1_op_l1_q  <= e1_op_l1_d;
            e1_op_l2_q  <= e1_op_l2_d;
            e1_opr1_q   <= e1_opr1_d;
            e1_opr2_q   <= e1_opr2_d;
            e1_rob_id_q <= e1_rob_id_d;
            alu_valid_q <= alu_valid_d;
            alu_value_q <= alu_value_d;
            alu_dep_q   <= alu_dep_d;
        end
    end

    assign alu_valid      = alu_valid_q;
    assign alu_value      = alu_value_q;
    assign alu_dependency = alu_dep_q;

endmodule
